// File: rtl/interval_timer_ctrl_if.sv
// Command/status bundle between the control logic and interval_timer_ctrl.
// master = control side driving commands, slave = the timer controller.
interface interval_timer_ctrl_if #(
  parameter int W = 4
);
  logic         start;
  logic         stop;
  logic         hold;
  logic         mode;
  logic [W-1:0] limit;
  logic [W-1:0] q;
  logic         tick;
  logic         busy;
  logic         done;
  logic [3:0]   periods;

  modport master (
    output start, stop, hold, mode, limit,
    input  q, tick, busy, done, periods
  );

  modport slave (
    input  start, stop, hold, mode, limit,
    output q, tick, busy, done, periods
  );
endinterface

// File: rtl/interval_timer_ctrl.sv
// Interval sequencer for a W-bit loadable up-counter: one-shot/periodic wraps with tick.
// Optional prescaler enabled by defining INTERVAL_TIMER_CTRL_PRESCALE_EN.
module interval_timer_ctrl #(
  parameter int W     = 4,
  parameter int PRE_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  interval_timer_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;

  logic [W-1:0] q_r;
  logic [W-1:0] q_next;
  logic [W-1:0] lim_r;
  logic [W-1:0] lim_next;
  logic         mode_r;
  logic         mode_next;
  logic         tick_r;
  logic         tick_next;
  logic [3:0]   per_r;
  logic [3:0]   per_next;
  logic         busy_r;
  logic         done_r;

  logic         adv;
  logic         load;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // A start is taken only from IDLE or DONE; in DONE a simultaneous stop wins.
  always_comb begin
    load = 1'b0;
    if (bus.start && (bus.limit != '0)) begin
      if (state == IDLE)
        load = 1'b1;
      else if (state == DONE && !bus.stop)
        load = 1'b1;
    end
  end

`ifdef INTERVAL_TIMER_CTRL_PRESCALE_EN
  logic [PRE_W-1:0] pre_r;
  logic [PRE_W-1:0] pre_next;

  always_comb begin
    pre_next = pre_r;
    if (load || bus.stop || (state == RUN && state_next == DONE))
      pre_next = '0;
    else if (state == RUN && !bus.hold)
      pre_next = pre_r + PRE_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pre_r <= '0;
    else
      pre_r <= pre_next;
  end

  assign adv = !bus.hold && (&pre_r);
`else
  assign adv = !bus.hold;

  // PRE_W only sizes the prescaler; referenced here so both builds share one parameter list.
  if (PRE_W < 1) begin : g_pre_w_unused
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load)
          state_next = RUN;
      end
      RUN: begin
        if (bus.stop)
          state_next = IDLE;
        else if (adv && (q_r == lim_r) && !mode_r)
          state_next = DONE;
      end
      DONE: begin
        if (bus.stop)
          state_next = IDLE;
        else if (load)
          state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values of every registered output and the sampled command fields.
  always_comb begin
    q_next    = q_r;
    tick_next = 1'b0;
    per_next  = per_r;
    lim_next  = lim_r;
    mode_next = mode_r;

    case (state)
      RUN: begin
        if (bus.stop) begin
          q_next = '0;
        end else if (adv) begin
          if (q_r == lim_r) begin
            q_next    = '0;
            tick_next = 1'b1;
            per_next  = sat_inc(per_r);
          end else begin
            q_next = q_r + W'(1);
          end
        end
      end
      default: q_next = '0;
    endcase

    if (load) begin
      lim_next  = bus.limit;
      mode_next = bus.mode;
      q_next    = '0;
      per_next  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r    <= '0;
      lim_r  <= '0;
      mode_r <= 1'b0;
      tick_r <= 1'b0;
      per_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      q_r    <= q_next;
      lim_r  <= lim_next;
      mode_r <= mode_next;
      tick_r <= tick_next;
      per_r  <= per_next;
      busy_r <= (state_next == RUN);
      done_r <= (state_next == DONE);
    end
  end

  assign bus.q       = q_r;
  assign bus.tick    = tick_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.periods = per_r;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl: interval-count model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_interval_timer_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  interval_timer_ctrl_if #(.W(W)) bus ();

  interval_timer_ctrl #(.W(W), .PRE_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: counts advancing cycles since start; q and periods follow arithmetically.
  typedef struct {
    bit active;
    bit done;
    bit tick;
    bit mode;
    int n;
    int lim;
    int per_hold;
  } mstate_t;

  mstate_t m;

  function automatic int exp_q(input mstate_t s);
    return s.active ? (s.n % (s.lim + 1)) : 0;
  endfunction

  function automatic int exp_per(input mstate_t s);
    int p;
    if (!s.active) return s.per_hold;
    p = s.n / (s.lim + 1);
    return (p > 15) ? 15 : p;
  endfunction

  function automatic mstate_t step(input mstate_t s, input bit start, input bit stop,
                                   input bit hold, input bit mode, input int limit);
    mstate_t r;
    r = s;
    r.tick = 1'b0;
    if (s.active) begin
      if (stop) begin
        r.per_hold = exp_per(s);
        r.active = 1'b0;
      end else if (!hold) begin
        r.n = s.n + 1;
        if (r.n % (s.lim + 1) == 0) begin
          r.tick = 1'b1;
          if (!s.mode) begin
            r.per_hold = exp_per(r);
            r.active = 1'b0;
            r.done = 1'b1;
          end
        end
      end
    end else if (s.done && stop) begin
      r.done = 1'b0;
    end else if (start && limit != 0) begin
      r.active = 1'b1;
      r.done = 1'b0;
      r.n = 0;
      r.lim = limit;
      r.mode = mode;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst)
      m <= '{active: 1'b0, done: 1'b0, tick: 1'b0, mode: 1'b0, n: 0, lim: 0, per_hold: 0};
    else
      m <= step(m, bus.start, bus.stop, bus.hold, bus.mode, int'(bus.limit));
  end

  always @(negedge clk) begin
    if (rst) begin
      check("model_q", int'(bus.q), exp_q(m));
      check("model_tick", int'(bus.tick), int'(m.tick));
      check("model_busy", int'(bus.busy), int'(m.active));
      check("model_done", int'(bus.done), int'(m.done));
      check("model_periods", int'(bus.periods), exp_per(m));
    end
  end

  task automatic start_seq(input int lim, input bit md);
    bus.start = 1'b1;
    bus.limit = W'(lim);
    bus.mode  = md;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_q(input int v, input int budget, output int cyc);
    cyc = 0;
    while (int'(bus.q) != v && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (int'(bus.q) != v) check("wait_q_timeout", int'(bus.q), v);
  endtask

  task automatic wait_tick(input int budget, output int cyc);
    cyc = 0;
    while (bus.tick !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.tick !== 1'b1) check("wait_tick_timeout", int'(bus.tick), 1);
  endtask

  initial begin
    int k;
    int w;
    int ticks;
    int last;
    int maxq;

    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.hold  = 1'b0;
    bus.mode  = 1'b0;
    bus.limit = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_q", int'(bus.q), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_periods", int'(bus.periods), 0);
    rst = 1'b1;

    // One-shot, limit 5
    start_seq(5, 1'b0);
    check("os_busy_entry", int'(bus.busy), 1);
    check("os_q_entry", int'(bus.q), 0);
    k = 0;
    ticks = 0;
    while (bus.done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
      ticks += int'(bus.tick);
    end
    check("os_len", k, 6);
    check("os_ticks", ticks, 1);
    check("os_tick_at_done", int'(bus.tick), 1);
    check("os_periods", int'(bus.periods), 1);
    check("os_busy_end", int'(bus.busy), 0);
    @(negedge clk);
    check("os_tick_one_cycle", int'(bus.tick), 0);
    check("os_done_held", int'(bus.done), 1);

    // start + stop together in DONE
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    bus.limit = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("ss_done", int'(bus.done), 0);
    check("ss_busy", int'(bus.busy), 0);

    // Periodic, limit 2
    start_seq(2, 1'b1);
    ticks = 0;
    last = 0;
    for (int c = 1; c <= 65; c++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) begin
        ticks++;
        if (ticks == 1) check("per_first_tick", c, 3);
        if (ticks == 1) check("per_p1", int'(bus.periods), 1);
        if (ticks == 2) check("per_p2", int'(bus.periods), 2);
        if (ticks > 1) check("per_gap", c - last, 3);
        last = c;
      end
    end
    check("per_ticks", ticks, 21);
    check("per_sat", int'(bus.periods), 15);
    check("per_busy", int'(bus.busy), 1);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("per_stop_busy", int'(bus.busy), 0);
    check("per_stop_periods", int'(bus.periods), 15);

    // Hold, limit 5 periodic
    start_seq(5, 1'b1);
    wait_q(3, 20, w);
    bus.hold = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("hold_q", int'(bus.q), 3);
      check("hold_tick", int'(bus.tick), 0);
    end
    bus.hold = 1'b0;
    wait_tick(20, k);
    check("hold_tick_total", w + 4 + k, 10);
    repeat (2) @(negedge clk);
    bus.hold = 1'b1;
    bus.stop = 1'b1;
    @(negedge clk);
    bus.hold = 1'b0;
    bus.stop = 1'b0;
    check("hold_stop_busy", int'(bus.busy), 0);
    check("hold_stop_q", int'(bus.q), 0);
    check("hold_stop_periods", int'(bus.periods), 1);

    // Stop on the wrap cycle, limit 3 periodic
    start_seq(3, 1'b1);
    wait_tick(20, k);
    check("sw_first_tick", k, 4);
    wait_q(3, 20, w);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("sw_busy", int'(bus.busy), 0);
    check("sw_q", int'(bus.q), 0);
    check("sw_tick", int'(bus.tick), 0);
    check("sw_periods", int'(bus.periods), 1);
    @(negedge clk);
    check("sw_tick_after", int'(bus.tick), 0);

    // start with limit 0 is ignored
    start_seq(0, 1'b0);
    check("lim0_busy", int'(bus.busy), 0);
    @(negedge clk);
    check("lim0_busy2", int'(bus.busy), 0);

    // Full range, limit 15 one-shot
    start_seq(15, 1'b0);
    k = 0;
    maxq = int'(bus.q);
    while (bus.done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
      if (int'(bus.q) > maxq) maxq = int'(bus.q);
    end
    check("full_maxq", maxq, 15);
    check("full_len", k, 16);
    check("full_tick", int'(bus.tick), 1);
    check("full_q_wrap", int'(bus.q), 0);

    // Asynchronous reset mid-run, limit 7
    start_seq(7, 1'b0);
    wait_q(4, 20, w);
    check("ar_q_before", int'(bus.q), 4);
    #2 rst = 1'b0;
    #1;
    check("ar_q", int'(bus.q), 0);
    check("ar_busy", int'(bus.busy), 0);
    check("ar_tick", int'(bus.tick), 0);
    check("ar_done", int'(bus.done), 0);
    check("ar_periods", int'(bus.periods), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ar_idle_after", int'(bus.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/interval_timer_ctrl.md
Name: interval_timer_ctrl

Overview:
- Sequencing controller for a W-bit loadable synchronous up-counter, giving programmable interval timing for the counter datapath.
- Accepts a start command with a terminal value and a mode. Drives count-enable and load of the counter. Emits a one-cycle tick at each wrap.
- One-shot mode stops after a single interval. Periodic mode repeats and tracks completed periods.
- Sits between the control logic and the counter; replaces ad-hoc enable/reset gluing around the counter.

Parameters:
- W, 4, counter and limit width.
- PRE_W, 2, prescaler width; used only when PRESCALE_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (rst=0 resets).
- start  input  1  begin an interval sequence; sampled in IDLE and DONE.
- stop  input  1  abort the sequence; return to IDLE.
- hold  input  1  freeze counting while in RUN.
- mode  input  1  0 = one-shot, 1 = periodic; sampled on accepted start.
- limit  input  W  terminal count; sampled on accepted start.
- q  output  W  current count.
- tick  output  1  one-cycle pulse on each wrap.
- busy  output  1  high in RUN.
- done  output  1  high in DONE, i.e. after a one-shot completes.
- periods  output  4  completed periods since start, saturating.

Behaviour:
- Reset: state=IDLE; q=0, tick=0, busy=0, done=0, periods=0; internal lim_r=0, mode_r=0. Reset is applied immediately when rst falls, including mid-RUN.
- All outputs are registered.
- States are IDLE, RUN and DONE; busy = (state==RUN) and done = (state==DONE).
- IDLE:
  - start=1 and limit!=0 -> lim_r<=limit, mode_r<=mode, q<=0, periods<=0, state<=RUN.
  - start with limit==0 is ignored; state stays IDLE.
  - stop and hold have no effect in IDLE.
- RUN, advance condition: adv = !hold (and prescaler strobe if enabled).
- RUN, adv with q!=lim_r: q<=q+1.
- RUN, adv with q==lim_r (wrap):
  - q<=0 and tick<=1 for exactly one cycle; tick coincides with the cycle q shows 0 after the wrap.
  - periods<=periods+1, saturating at 15.
  - mode_r=0 -> state<=DONE; mode_r=1 -> stay in RUN.
- Interval length: lim_r+1 advancing cycles per period.
- RUN, stop=1:
  - Highest priority, including over a wrap in the same cycle: state<=IDLE, q<=0.
  - No tick is issued and periods is held.
- RUN, start=1: ignored; lim_r and mode_r are not resampled.
- RUN, hold=1 with stop=0: q, periods and the prescaler freeze; tick=0.
- DONE:
  - q=0 and periods is held.
  - start with limit!=0 behaves as in IDLE, giving a direct DONE->RUN transition that clears done.
  - stop -> IDLE.
  - start and stop together -> stop wins.
- Wrap-around: q never exceeds lim_r. With limit = 2^W-1 the count runs over the full range, 2^W-1 -> 0.
- Arithmetic: all increments are modulo their width except periods, which saturates.

Optional Feature:
- Macro: INTERVAL_TIMER_CTRL_PRESCALE_EN.
- Defined:
  - An internal PRE_W-bit prescaler increments on every non-hold RUN cycle; adv is true only when the prescaler is all-ones.
  - Each period therefore takes (lim_r+1)*2^PRE_W cycles.
  - The prescaler clears on accepted start, on stop, on reset and on entering DONE.
- Undefined: no prescaler; adv = !hold; PRE_W is unused and there is no logic overhead.

Test Plan:
1. Reset: start a run with limit=7, pulse rst=0 asynchronously while q=4 -> q=0, busy=0, tick=0, done=0 and periods=0 immediately, without waiting for a clock edge.
2. One-shot, limit=5, mode=0, 1-cycle start -> busy=1 next edge; q runs 0,1,2,3,4,5,0; tick=1 for exactly one cycle when q returns to 0; done=1, busy=0, periods=1; 6 cycles from RUN entry to DONE.
3. Periodic, limit=2, mode=1 -> tick every 3 cycles; periods 1,2,3,... and stays at 15 after 20 wraps; busy remains 1.
4. Hold, limit=5: at q=3 assert hold for 4 cycles -> q stays 3 and tick is delayed by exactly 4 cycles; then assert stop together with hold -> IDLE, q=0.
5. Stop on the wrap cycle, limit=3, stop high when q=3 -> IDLE, q=0, no tick pulse, periods unchanged.
6. Edge cases:
   - start with limit=0 -> stays in IDLE, busy=0.
   - W=4, limit=15 -> q reaches 15 then wraps to 0 with tick.
   - start and stop together in DONE -> IDLE.
